// File: rtl/frame_sink_pkg.sv
// Shared types and sizing for the frame sink: FSM state encoding and default
// buffer geometry.
package frame_sink_pkg;

    localparam int FS_DEPTH = 16;
    localparam int FS_W     = 8;
    localparam int LEN_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_DRAIN,
        ST_SUMMARY
    } state_e;

endpackage

// File: rtl/frame_buf.sv
// Frame byte store: DEPTH x W register array with a write pointer and a
// two-byte read port addressed by a read pointer that steps one pair at a time.
module frame_buf
    import frame_sink_pkg::*;
#(
    parameter int DEPTH = FS_DEPTH,
    parameter int W     = FS_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [W-1:0]     din,
    input  logic             rd_adv,
    output logic [LEN_W-1:0] rd_ptr,
    output logic [W-1:0]     rd_hi,
    output logic [W-1:0]     rd_lo
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    lo_idx;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en)  wr_ptr_d = wr_ptr_q + LEN_W'(1);
            if (rd_adv) rd_ptr_d = rd_ptr_q + LEN_W'(2);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Contents are don't-care after reset; only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

    assign lo_idx = rd_ptr_q[AW-1:0] + AW'(1);
    assign rd_ptr = rd_ptr_q;
    assign rd_hi  = mem_q[rd_ptr_q[AW-1:0]];
    assign rd_lo  = mem_q[lo_idx];

endmodule

// File: rtl/frame_sink.sv
// Byte-burst frame collector: buffers one burst, drains it as 2-byte words with
// ready/valid handshake, then pulses a length/sum/overflow summary.
//
// state      | meaning
// ST_IDLE    | waiting for the first byte of a burst
// ST_RECV    | storing bytes while i_valid stays high
// ST_DRAIN   | presenting stored byte pairs on o_word
// ST_SUMMARY | done pulse, frame bookkeeping cleared
module frame_sink
    import frame_sink_pkg::*;
#(
    parameter int DEPTH = FS_DEPTH,
    parameter int W     = FS_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    input  logic [W-1:0]     Din,
    output logic             busy,
    output logic [2*W-1:0]   o_word,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             o_last,
    output logic             o_odd,
    output logic             done,
    output logic [LEN_W-1:0] frame_len,
    output logic [W-1:0]     frame_sum,
    output logic             frame_ovf,
    output logic             proto_err
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             ovf_q, ovf_d;
    logic [2*W-1:0]   o_word_q, o_word_d;
    logic             o_valid_q, o_valid_d;
    logic             o_last_q, o_last_d;
    logic             o_odd_q, o_odd_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] frame_len_q, frame_len_d;
    logic [W-1:0]     frame_sum_q, frame_sum_d;
    logic             frame_ovf_q, frame_ovf_d;
    logic             proto_err_q, proto_err_d;

    logic             buf_clr, buf_wr, buf_adv;
    logic [LEN_W-1:0] rd_ptr, rem;
    logic [W-1:0]     rd_hi, rd_lo;

    frame_buf #(.DEPTH(DEPTH), .W(W)) u_buf (
        .clk    (clk),
        .reset  (reset),
        .clr    (buf_clr),
        .wr_en  (buf_wr),
        .din    (Din),
        .rd_adv (buf_adv),
        .rd_ptr (rd_ptr),
        .rd_hi  (rd_hi),
        .rd_lo  (rd_lo)
    );

    assign rem = len_q - rd_ptr;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;
        o_word_d    = o_word_q;
        o_valid_d   = o_valid_q;
        o_last_d    = o_last_q;
        o_odd_d     = o_odd_q;
        done_d      = 1'b0;
        frame_len_d = frame_len_q;
        frame_sum_d = frame_sum_q;
        frame_ovf_d = frame_ovf_q;
        proto_err_d = proto_err_q;
        buf_clr     = 1'b0;
        buf_wr      = 1'b0;
        buf_adv     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    buf_wr  = 1'b1;
                    len_d   = LEN_W'(1);
                    sum_d   = Din;
                    ovf_d   = 1'b0;
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                if (i_valid) begin
                    if (len_q == LEN_W'(DEPTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        buf_wr = 1'b1;
                        len_d  = len_q + LEN_W'(1);
                        sum_d  = sum_q + Din;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (i_valid) proto_err_d = 1'b1;
                if (o_valid_q && o_ready && o_last_q) begin
                    o_valid_d   = 1'b0;
                    o_last_d    = 1'b0;
                    o_odd_d     = 1'b0;
                    done_d      = 1'b1;
                    frame_len_d = len_q;
                    frame_sum_d = sum_q;
                    frame_ovf_d = ovf_q;
                    state_d     = ST_SUMMARY;
                end else if (!o_valid_q || o_ready) begin
                    // Load the next pair; a lone trailing byte is padded with zero.
                    buf_adv   = 1'b1;
                    o_valid_d = 1'b1;
                    o_last_d  = (rem <= LEN_W'(2));
                    o_odd_d   = (rem == LEN_W'(1));
                    o_word_d  = {rd_hi, (rem == LEN_W'(1)) ? {W{1'b0}} : rd_lo};
                end
            end
            ST_SUMMARY: begin
                if (i_valid) proto_err_d = 1'b1;
                buf_clr = 1'b1;
                len_d   = '0;
                sum_d   = '0;
                ovf_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            o_word_q    <= '0;
            o_valid_q   <= 1'b0;
            o_last_q    <= 1'b0;
            o_odd_q     <= 1'b0;
            done_q      <= 1'b0;
            frame_len_q <= '0;
            frame_sum_q <= '0;
            frame_ovf_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            o_word_q    <= o_word_d;
            o_valid_q   <= o_valid_d;
            o_last_q    <= o_last_d;
            o_odd_q     <= o_odd_d;
            done_q      <= done_d;
            frame_len_q <= frame_len_d;
            frame_sum_q <= frame_sum_d;
            frame_ovf_q <= frame_ovf_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign o_word    = o_word_q;
    assign o_valid   = o_valid_q;
    assign o_last    = o_last_q;
    assign o_odd     = o_odd_q;
    assign done      = done_q;
    assign frame_len = frame_len_q;
    assign frame_sum = frame_sum_q;
    assign frame_ovf = frame_ovf_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_frame_sink.sv
// Directed self-checking bench for frame_sink: one task per scenario with
// hand-computed expected words and summaries.
module tb_frame_sink;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_valid = 1'b0;
    logic [7:0]  Din = 8'h00;
    logic        o_ready = 1'b0;
    logic        busy;
    logic [15:0] o_word;
    logic        o_valid;
    logic        o_last;
    logic        o_odd;
    logic        done;
    logic [4:0]  frame_len;
    logic [7:0]  frame_sum;
    logic        frame_ovf;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  burst_q[$];
    logic [15:0] wq[$];
    logic        lq[$];
    logic        oq[$];
    logic        got_done;
    int          done_cycles;
    int          hold_changes;
    int          first_valid_c;
    int          last_valid_c;
    logic [4:0]  s_len;
    logic [7:0]  s_sum;
    logic        s_ovf;
    logic        busy_at_done;
    logic        busy_after;
    logic        done_after;
    logic        busy_after_first;

    frame_sink dut (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (i_valid),
        .Din       (Din),
        .busy      (busy),
        .o_word    (o_word),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_last    (o_last),
        .o_odd     (o_odd),
        .done      (done),
        .frame_len (frame_len),
        .frame_sum (frame_sum),
        .frame_ovf (frame_ovf),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_burst();
        for (int i = 0; i < burst_q.size(); i++) begin
            i_valid = 1'b1;
            Din     = burst_q[i];
            tick();
            if (i == 0) busy_after_first = busy;
        end
        i_valid = 1'b0;
        Din     = 8'h00;
    endtask

    // Observes the drain phase at posedge+1; o_ready set here applies to the next edge.
    task automatic collect(input int stall_n, input int inj_cycle);
        logic [15:0] held;
        int stalled;
        held = '0;
        stalled = 0;
        wq.delete(); lq.delete(); oq.delete();
        got_done = 1'b0; done_cycles = 0; hold_changes = 0;
        first_valid_c = -1; last_valid_c = -1;
        for (int c = 0; c < 100 && !got_done; c++) begin
            if (c == inj_cycle) begin
                i_valid = 1'b1; Din = 8'h77;
            end else begin
                i_valid = 1'b0; Din = 8'h00;
            end
            o_ready = 1'b0;
            if (done) begin
                got_done = 1'b1;
                done_cycles++;
                s_len = frame_len; s_sum = frame_sum; s_ovf = frame_ovf;
                busy_at_done = busy;
            end else if (o_valid) begin
                if (first_valid_c < 0) first_valid_c = c;
                if (stalled < stall_n) begin
                    if (stalled == 0) held = o_word;
                    else if (o_word !== held) hold_changes++;
                    stalled++;
                end else begin
                    if (stall_n > 0 && wq.size() == 0 && o_word !== held) hold_changes++;
                    o_ready = 1'b1;
                    wq.push_back(o_word); lq.push_back(o_last); oq.push_back(o_odd);
                    last_valid_c = c;
                end
            end
            tick();
        end
        i_valid = 1'b0; Din = 8'h00; o_ready = 1'b0;
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({busy, o_valid, o_word, o_last, o_odd, done, frame_len, frame_sum, frame_ovf, proto_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b o_valid=%b o_word=%h done=%b len=%0d sum=%h ovf=%b perr=%b, required all zero",
                     busy, o_valid, o_word, done, frame_len, frame_sum, frame_ovf, proto_err);
        end
        tick(); tick();
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_basic();
        burst_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_burst();
        collect(0, -1);
        checks++;
        if (busy_after_first !== 1'b1) begin
            errors++; $display("FAIL basic_busy_first: got %b, required 1", busy_after_first);
        end
        checks++;
        if (got_done !== 1'b1 || done_cycles != 1) begin
            errors++; $display("FAIL basic_done: got done=%b cycles=%0d, required 1 and 1", got_done, done_cycles);
        end
        checks++;
        if (wq.size() != 2) begin
            errors++; $display("FAIL basic_count: got %0d words, required 2", wq.size());
        end else begin
            checks++;
            if (wq[0] !== 16'h0102 || wq[1] !== 16'h0304) begin
                errors++; $display("FAIL basic_words: got %h %h, required 0102 0304", wq[0], wq[1]);
            end
            checks++;
            if (lq[0] !== 1'b0 || lq[1] !== 1'b1 || oq[0] !== 1'b0 || oq[1] !== 1'b0) begin
                errors++; $display("FAIL basic_flags: got last=%b%b odd=%b%b, required last=01 odd=00", lq[0], lq[1], oq[0], oq[1]);
            end
        end
        checks++;
        if (s_len !== 5'd4 || s_sum !== 8'h0A || s_ovf !== 1'b0) begin
            errors++; $display("FAIL basic_summary: got len=%0d sum=%h ovf=%b, required len=4 sum=0a ovf=0", s_len, s_sum, s_ovf);
        end
        checks++;
        if (first_valid_c != 2) begin
            errors++; $display("FAIL basic_first_valid: got cycle %0d, required 2", first_valid_c);
        end
        checks++;
        if (busy_at_done !== 1'b1 || busy_after !== 1'b0 || done_after !== 1'b0) begin
            errors++; $display("FAIL basic_busy_done: got busy_at_done=%b busy_after=%b done_after=%b, required 1 0 0",
                               busy_at_done, busy_after, done_after);
        end
    endtask

    task automatic test_odd();
        burst_q = '{8'hAA, 8'hBB, 8'hCC};
        send_burst();
        collect(0, -1);
        checks++;
        if (wq.size() != 2) begin
            errors++; $display("FAIL odd_count: got %0d words, required 2", wq.size());
        end else begin
            checks++;
            if (wq[0] !== 16'hAABB || wq[1] !== 16'hCC00) begin
                errors++; $display("FAIL odd_words: got %h %h, required aabb cc00", wq[0], wq[1]);
            end
            checks++;
            if (lq[0] !== 1'b0 || lq[1] !== 1'b1 || oq[0] !== 1'b0 || oq[1] !== 1'b1) begin
                errors++; $display("FAIL odd_flags: got last=%b%b odd=%b%b, required last=01 odd=01", lq[0], lq[1], oq[0], oq[1]);
            end
        end
        checks++;
        if (got_done !== 1'b1 || s_len !== 5'd3 || s_sum !== 8'h31 || s_ovf !== 1'b0) begin
            errors++; $display("FAIL odd_summary: got done=%b len=%0d sum=%h ovf=%b, required 1 3 31 0", got_done, s_len, s_sum, s_ovf);
        end
        tick(); tick(); tick();
        checks++;
        if (frame_len !== 5'd3 || frame_sum !== 8'h31 || frame_ovf !== 1'b0) begin
            errors++; $display("FAIL odd_summary_hold: got len=%0d sum=%h ovf=%b, required 3 31 0", frame_len, frame_sum, frame_ovf);
        end
    endtask

    task automatic test_overflow();
        burst_q.delete();
        for (int i = 1; i <= 18; i++) burst_q.push_back(8'(i));
        send_burst();
        collect(0, -1);
        checks++;
        if (wq.size() != 8) begin
            errors++; $display("FAIL ovf_count: got %0d words, required 8", wq.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                logic [15:0] exp_w;
                exp_w = {8'(2*k + 1), 8'(2*k + 2)};
                checks++;
                if (wq[k] !== exp_w || lq[k] !== (k == 7) || oq[k] !== 1'b0) begin
                    errors++; $display("FAIL ovf_word%0d: got %h last=%b odd=%b, required %h last=%b odd=0",
                                       k, wq[k], lq[k], oq[k], exp_w, (k == 7));
                end
            end
        end
        checks++;
        if (last_valid_c - first_valid_c != 7) begin
            errors++; $display("FAIL ovf_throughput: got span %0d cycles, required 7", last_valid_c - first_valid_c);
        end
        checks++;
        if (got_done !== 1'b1 || s_len !== 5'd16 || s_sum !== 8'h88 || s_ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_summary: got done=%b len=%0d sum=%h ovf=%b, required 1 16 88 1", got_done, s_len, s_sum, s_ovf);
        end
    endtask

    task automatic test_stall();
        burst_q = '{8'h10, 8'h20, 8'h30, 8'h40};
        send_burst();
        collect(5, -1);
        checks++;
        if (hold_changes != 0) begin
            errors++; $display("FAIL stall_hold: got %0d changes of o_word during stall, required 0", hold_changes);
        end
        checks++;
        if (wq.size() != 2) begin
            errors++; $display("FAIL stall_count: got %0d words, required 2", wq.size());
        end else begin
            checks++;
            if (wq[0] !== 16'h1020 || wq[1] !== 16'h3040 || lq[1] !== 1'b1) begin
                errors++; $display("FAIL stall_words: got %h %h last=%b, required 1020 3040 last=1", wq[0], wq[1], lq[1]);
            end
        end
        checks++;
        if (got_done !== 1'b1 || s_len !== 5'd4 || s_sum !== 8'hA0) begin
            errors++; $display("FAIL stall_summary: got done=%b len=%0d sum=%h, required 1 4 a0", got_done, s_len, s_sum);
        end
    endtask

    task automatic test_proto();
        checks++;
        if (proto_err !== 1'b0) begin
            errors++; $display("FAIL proto_pre: got %b, required 0", proto_err);
        end
        burst_q = '{8'h11, 8'h22, 8'h33};
        send_burst();
        collect(0, 2);
        checks++;
        if (wq.size() != 2) begin
            errors++; $display("FAIL proto_count: got %0d words, required 2", wq.size());
        end else begin
            checks++;
            if (wq[0] !== 16'h1122 || wq[1] !== 16'h3300 || oq[1] !== 1'b1) begin
                errors++; $display("FAIL proto_words: got %h %h odd=%b, required 1122 3300 odd=1", wq[0], wq[1], oq[1]);
            end
        end
        checks++;
        if (got_done !== 1'b1 || s_len !== 5'd3 || s_sum !== 8'h66 || s_ovf !== 1'b0) begin
            errors++; $display("FAIL proto_summary: got done=%b len=%0d sum=%h ovf=%b, required 1 3 66 0", got_done, s_len, s_sum, s_ovf);
        end
        tick(); tick(); tick();
        checks++;
        if (proto_err !== 1'b1) begin
            errors++; $display("FAIL proto_sticky: got %b, required 1", proto_err);
        end
    endtask

    task automatic test_mid_reset();
        logic saw_done;
        burst_q = '{8'h01, 8'h02, 8'h03};
        send_burst();
        tick(); tick();
        checks++;
        if (o_valid !== 1'b1 || o_word !== 16'h0102) begin
            errors++; $display("FAIL midrst_pre: got o_valid=%b o_word=%h, required 1 0102", o_valid, o_word);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({busy, o_valid, o_word, o_last, o_odd, done, frame_len, frame_sum, frame_ovf, proto_err} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got busy=%b o_valid=%b o_word=%h done=%b len=%0d sum=%h perr=%b, required all zero",
                     busy, o_valid, o_word, done, frame_len, frame_sum, proto_err);
        end
        tick(); tick();
        reset = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++; $display("FAIL midrst_no_done: got activity after release, required idle with no done");
        end
        burst_q = '{8'h05, 8'h06};
        send_burst();
        collect(0, -1);
        checks++;
        if (wq.size() != 1 || got_done !== 1'b1) begin
            errors++; $display("FAIL midrst_count: got %0d words done=%b, required 1 word done=1", wq.size(), got_done);
        end else begin
            checks++;
            if (wq[0] !== 16'h0506 || lq[0] !== 1'b1 || oq[0] !== 1'b0 || s_len !== 5'd2 || s_sum !== 8'h0B) begin
                errors++; $display("FAIL midrst_frame: got %h last=%b odd=%b len=%0d sum=%h, required 0506 1 0 2 0b",
                                   wq[0], lq[0], oq[0], s_len, s_sum);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_odd();
        test_overflow();
        test_stall();
        test_proto();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
